// File: rtl/csr_issue_buffer.sv
// rtl/csr_issue_buffer.sv - single-entry CSR instruction buffer between issue and commit
module csr_issue_buffer #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [3:0]               op_i,
  input  logic [11:0]              addr_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     commit_i,
  output logic                     commit_ready_o,
  output logic [3:0]               csr_op_o,
  output logic [11:0]              csr_addr_o,
  output logic [XLEN-1:0]          csr_wdata_o,
  input  logic [XLEN-1:0]          csr_rdata_i,
  input  logic                     csr_ex_valid_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_ex_o,
  output logic [15:0]              issued_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HELD = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  logic [1:0]               state_q;
  logic [1:0]               state_d;
  logic [3:0]               op_q;
  logic [11:0]              addr_q;
  logic [XLEN-1:0]          wdata_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [XLEN-1:0]          result_q;
  logic                     ex_q;
  logic [15:0]              cnt_q;
  logic                     accept;
  logic                     issue;

  assign accept = (state_q == IDLE) && valid_i && !flush_i && !rst_i;
  assign issue  = (state_q == HELD) && commit_i && !flush_i && !rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HELD;
      HELD:    if (issue) state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      id_q     <= '0;
      result_q <= '0;
      ex_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        id_q    <= trans_id_i;
      end
      // Faulting accesses never expose read data to writeback.
      if (issue) begin
        result_q <= csr_ex_valid_i ? '0 : csr_rdata_i;
        ex_q     <= csr_ex_valid_i;
        cnt_q    <= cnt_q + 16'd1;
      end
    end
  end

  assign ready_o        = (state_q == IDLE);
  assign commit_ready_o = (state_q == HELD);
  assign csr_op_o       = issue ? op_q : 4'd0;
  assign csr_addr_o     = issue ? addr_q : 12'd0;
  assign csr_wdata_o    = issue ? wdata_q : '0;
  assign wb_valid_o     = (state_q == WB) && !flush_i && !rst_i;
  assign wb_trans_id_o  = id_q;
  assign wb_result_o    = result_q;
  assign wb_ex_o        = ex_q;
  assign issued_cnt_o   = cnt_q;

endmodule

// File: tb/tb_csr_issue_buffer.sv
// tb/tb_csr_issue_buffer.sv - directed and randomized bench for csr_issue_buffer
module tb_csr_issue_buffer;

  logic        clk = 1'b0;
  logic        rst, flush, valid, commit, exv;
  logic        ready, commit_ready, wb_valid, wb_ex;
  logic [3:0]  op, csr_op;
  logic [11:0] addr, csr_addr;
  logic [63:0] wdata, csr_wdata, rdata, wb_result;
  logic [2:0]  tid, wb_id;
  logic [15:0] cnt;

  csr_issue_buffer #(.XLEN(64), .TRANS_ID_BITS(3)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(ready),
    .op_i(op), .addr_i(addr), .wdata_i(wdata), .trans_id_i(tid),
    .commit_i(commit), .commit_ready_o(commit_ready),
    .csr_op_o(csr_op), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .csr_rdata_i(rdata), .csr_ex_valid_i(exv),
    .wb_valid_o(wb_valid), .wb_trans_id_o(wb_id), .wb_result_o(wb_result),
    .wb_ex_o(wb_ex), .issued_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  bit do_chk = 1'b1;

  // Transaction-level reference: is an instruction held, is a writeback due.
  bit          m_held, m_wb;
  logic [3:0]  h_op;
  logic [11:0] h_addr;
  logic [63:0] h_wdata, w_res;
  logic [2:0]  h_id, w_id;
  logic        w_ex;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic put(input logic r, input logic f, input logic v, input logic c);
    rst = r; flush = f; valid = v; commit = c;
    #1;
  endtask

  task automatic tick();
    logic iss, wbv;
    iss = m_held && commit && !flush && !rst;
    wbv = m_wb && !flush && !rst;
    if (do_chk) begin
      chk("ready", ready, !m_held && !m_wb);
      chk("commit_ready", commit_ready, m_held);
      chk("csr_op", csr_op, iss ? h_op : 4'd0);
      chk("csr_addr", csr_addr, iss ? h_addr : 12'd0);
      chk("csr_wdata", csr_wdata, iss ? h_wdata : 64'd0);
      chk("wb_valid", wb_valid, wbv);
      if (wbv) begin
        chk("wb_id", wb_id, w_id);
        chk("wb_result", wb_result, w_res);
        chk("wb_ex", wb_ex, w_ex);
      end
      chk("issued_cnt", cnt, m_cnt);
    end
    @(posedge clk);
    if (rst) begin
      m_held = 0; m_wb = 0; h_op = 0; h_addr = 0; h_wdata = 0; h_id = 0;
      w_id = 0; w_res = 0; w_ex = 0; m_cnt = 0;
    end else if (flush) begin
      m_held = 0; m_wb = 0;
    end else if (!m_held && !m_wb && valid) begin
      m_held = 1; h_op = op; h_addr = addr; h_wdata = wdata; h_id = tid;
    end else if (iss) begin
      m_held = 0; m_wb = 1; w_id = h_id; w_ex = exv;
      w_res = exv ? 64'd0 : rdata;
      m_cnt = m_cnt + 16'd1;
    end else if (m_wb) begin
      m_wb = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    m_held = 0; m_wb = 0; h_op = 0; h_addr = 0; h_wdata = 0; h_id = 0;
    w_id = 0; w_res = 0; w_ex = 0; m_cnt = 0;
    op = 0; addr = 0; wdata = 0; tid = 0; rdata = 0; exv = 0;
    rst = 1; flush = 0; valid = 0; commit = 0;
    @(negedge clk);

    // reset, then reset values
    put(1, 0, 0, 0); tick();
    put(1, 0, 1, 1); tick();
    put(0, 0, 0, 0);
    chk("rst_ready", ready, 1); chk("rst_commit_ready", commit_ready, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_csr_op", csr_op, 0);
    chk("rst_csr_addr", csr_addr, 0); chk("rst_csr_wdata", csr_wdata, 0);
    chk("rst_wb_ex", wb_ex, 0); chk("rst_cnt", cnt, 0);
    tick();

    // basic path
    op = 4'd1; addr = 12'h300; wdata = 64'h8; tid = 3'd5;
    put(0, 0, 1, 0); tick();
    op = 0; addr = 0; wdata = 0; tid = 0;
    put(0, 0, 0, 0); tick();
    rdata = 64'hA00;
    put(0, 0, 0, 1);
    chk("basic_op", csr_op, 1); chk("basic_addr", csr_addr, 12'h300);
    chk("basic_wdata", csr_wdata, 64'h8);
    tick();
    put(0, 0, 0, 0);
    chk("basic_wb_valid", wb_valid, 1); chk("basic_wb_id", wb_id, 5);
    chk("basic_wb_result", wb_result, 64'hA00); chk("basic_cnt", cnt, 1);
    chk("basic_wb_op_none", csr_op, 0);
    tick();
    put(0, 0, 0, 0); chk("basic_wb_once", wb_valid, 0); tick();

    // exception access
    op = 4'd2; addr = 12'h341; wdata = 64'hF0; tid = 3'd2;
    put(0, 0, 1, 0); tick();
    rdata = 64'h1234; exv = 1;
    put(0, 0, 0, 1); tick();
    exv = 0;
    put(0, 0, 0, 0);
    chk("ex_wb_valid", wb_valid, 1); chk("ex_wb_ex", wb_ex, 1);
    chk("ex_wb_result", wb_result, 0);
    tick();

    // flush while held, then flush coincident with commit
    op = 4'd3; addr = 12'h305; tid = 3'd1;
    put(0, 0, 1, 0); tick();
    put(0, 1, 0, 0); tick();
    put(0, 0, 0, 0); chk("flush_held_ready", ready, 1); chk("flush_held_cnt", cnt, 2); tick();
    put(0, 0, 1, 0); tick();
    put(0, 1, 0, 1); chk("flush_commit_op", csr_op, 0); tick();
    put(0, 0, 0, 0);
    chk("flush_commit_wb", wb_valid, 0); chk("flush_commit_ready", ready, 1);
    chk("flush_commit_cnt", cnt, 2);
    tick();
    put(0, 1, 1, 0); tick();
    put(0, 0, 0, 0); chk("flush_valid_ignored", commit_ready, 0); tick();

    // stall with valid held high, early commit ignored
    put(0, 0, 0, 1); chk("idle_commit_op", csr_op, 0); tick();
    op = 4'd1; addr = 12'h111; tid = 3'd3;
    put(0, 0, 1, 0); tick();
    addr = 12'h222; op = 4'd7;
    put(0, 0, 1, 0); chk("stall_ready", ready, 0); tick();
    put(0, 0, 1, 1); chk("stall_addr", csr_addr, 12'h111); chk("stall_op", csr_op, 1); tick();
    addr = 12'h333;
    put(0, 0, 1, 0); chk("stall_wb_ready", ready, 0); tick();
    put(0, 0, 1, 0); tick();
    put(0, 0, 0, 1); chk("stall_second_addr", csr_addr, 12'h333); tick();
    put(0, 0, 0, 0); tick();

    // reset during writeback
    put(0, 0, 1, 0); tick();
    put(0, 0, 0, 1); tick();
    put(1, 0, 0, 0); chk("rst_wb_valid_in_wb", wb_valid, 0); tick();
    put(0, 0, 0, 0);
    chk("rstwb_ready", ready, 1); chk("rstwb_wb_valid", wb_valid, 0);
    chk("rstwb_csr_op", csr_op, 0); chk("rstwb_wb_ex", wb_ex, 0); chk("rstwb_cnt", cnt, 0);
    tick();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom); addr = 12'($urandom); wdata = {$urandom, $urandom};
      tid = 3'($urandom); rdata = {$urandom, $urandom}; exv = ($urandom % 4) == 0;
      put(($urandom % 50) == 0, ($urandom % 8) == 0, 1'($urandom), 1'($urandom));
      tick();
    end

    // counter wrap
    exv = 0;
    put(1, 0, 0, 0); tick();
    do_chk = 0;
    for (int i = 0; i < 65535; i++) begin
      put(0, 0, 1, 0); tick();
      put(0, 0, 0, 1); tick();
      put(0, 0, 0, 0); tick();
    end
    do_chk = 1;
    put(0, 0, 0, 0); chk("wrap_preload", cnt, 16'hFFFF); tick();
    put(0, 0, 1, 0); tick();
    put(0, 0, 0, 1); tick();
    put(0, 0, 0, 0); chk("wrap_zero", cnt, 16'h0000); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csr_issue_buffer.md
CSR_ISSUE_BUFFER -- requirements
Module: csr_issue_buffer

Interface
REQ-001 Parameter XLEN, default 64, sets the CSR data width.
REQ-002 Parameter TRANS_ID_BITS, default 3, sets the scoreboard transaction ID width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk_i  in  1  clock; all state updates on the rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 flush_i  in  1  pipeline flush; discards any held instruction.
REQ-007 valid_i  in  1  issue stage presents a CSR instruction.
REQ-008 ready_o  out  1  buffer can accept an instruction.
REQ-009 op_i  in  4  CSR operation; 0 = NONE, 1 = RW, 2 = RS, 3 = RC, 4-15 = other, passed through unchanged.
REQ-010 addr_i  in  12  CSR address.
REQ-011 wdata_i  in  XLEN  CSR operand.
REQ-012 trans_id_i  in  TRANS_ID_BITS  scoreboard ID.
REQ-013 commit_i  in  1  commit stage retires the held CSR instruction.
REQ-014 commit_ready_o  out  1  a CSR instruction is held and can be committed.
REQ-015 csr_op_o  out  4  operation driven to the CSR register file.
REQ-016 csr_addr_o  out  12  address driven to the CSR register file.
REQ-017 csr_wdata_o  out  XLEN  write data driven to the CSR register file.
REQ-018 csr_rdata_i  in  XLEN  combinational read data from the register file.
REQ-019 csr_ex_valid_i  in  1  combinational access-exception flag from the register file.
REQ-020 wb_valid_o  out  1  writeback pulse.
REQ-021 wb_trans_id_o  out  TRANS_ID_BITS  writeback transaction ID.
REQ-022 wb_result_o  out  XLEN  old CSR value.
REQ-023 wb_ex_o  out  1  the access raised an exception.
REQ-024 issued_cnt_o  out  16  count of CSR accesses issued to the register file.

Function
REQ-025 The FSM SHALL have three states: IDLE, HELD and WB.
REQ-026 ready_o SHALL be 1 only in IDLE.
REQ-027 The buffer SHALL accept an instruction when valid_i && ready_o, registering op, addr, wdata and trans_id and moving to HELD next cycle.
REQ-028 valid_i SHALL be ignored while ready_o = 0.
REQ-029 commit_ready_o SHALL be 1 only in HELD; commit_i SHALL be ignored in any other state.
REQ-030 In HELD with commit_i = 1 and flush_i = 0, the block SHALL, in that same cycle, drive csr_op_o/csr_addr_o/csr_wdata_o from the held registers.
REQ-031 In that same commit cycle the block SHALL capture csr_rdata_i and csr_ex_valid_i into result registers and move to WB.
REQ-032 In every other cycle csr_op_o SHALL be 0 (NONE); csr_addr_o and csr_wdata_o SHALL be 0.
REQ-033 The register file SHALL see exactly one non-NONE op per committed instruction.
REQ-034 In WB, wb_valid_o SHALL be 1 for exactly one cycle with the captured trans_id, result and exception; the FSM SHALL return to IDLE next cycle.
REQ-035 wb_result_o SHALL be 0 whenever wb_ex_o = 1.
REQ-036 Latency: accept in cycle N, commit no earlier than N+1, writeback exactly one cycle after commit; the next accept occurs no earlier than the cycle after WB.
REQ-037 flush_i SHALL take priority in every state: the next state is IDLE, and wb_valid_o and csr_op_o are forced to 0 in the flush cycle.
REQ-038 A commit_i coincident with flush_i SHALL issue no register-file access and SHALL NOT increment the counter.
REQ-039 A valid_i coincident with flush_i in IDLE SHALL NOT be accepted.
REQ-040 issued_cnt_o SHALL increment by 1 on each REQ-030 issue cycle and wrap from 0xFFFF to 0x0000.
REQ-041 Held registers SHALL remain stable from accept until commit or flush, regardless of input changes.

Reset
REQ-042 In every cycle with rst_i = 1, the block SHALL enter IDLE on the next edge.
REQ-043 On reset, all held and result registers SHALL be cleared to 0 and issued_cnt_o SHALL be cleared to 0.
REQ-044 Reset values: ready_o = 1, commit_ready_o = 0, wb_valid_o = 0, csr_op_o = 0, csr_addr_o = 0, csr_wdata_o = 0, wb_ex_o = 0.
REQ-045 Reset asserted mid-operation (HELD or WB) SHALL abort the operation with no writeback and no register-file access.
REQ-046 While rst_i = 1, csr_op_o SHALL be 0 and wb_valid_o SHALL be 0.

Verification
REQ-047 Basic path: accept op=1 addr=0x300 wdata=0x8 id=5; commit 2 cycles later with csr_rdata_i=0xA00 -> csr_op_o=1 / addr 0x300 / wdata 0x8 for exactly the commit cycle, then wb_valid_o=1 with id 5 and result 0xA00; issued_cnt_o=1.
REQ-048 Exception: commit with csr_ex_valid_i=1 and csr_rdata_i=0x1234 -> wb_ex_o=1, wb_result_o=0.
REQ-049 Flush while HELD, and separately flush coincident with commit_i -> no non-NONE csr_op_o, no wb_valid_o, ready_o=1 next cycle, counter unchanged.
REQ-050 Stall and early commit: hold valid_i=1 continuously across two instructions; pulse commit_i while IDLE -> only one accept per IDLE visit, IDLE commit ignored, inputs changing during HELD do not alter csr_addr_o at commit.
REQ-051 Reset asserted in the WB cycle -> wb_valid_o=0 and all outputs at reset values next cycle.
REQ-052 Counter wrap: preload the counter to 0xFFFF via 65535 commits, then one more commit -> issued_cnt_o=0x0000.
